instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 The parameter LATENCY SHALL default to 2 and set the number of rising edges from the request-accepting edge to the edge at which en_ram_out is sampled high; legal range is 1..7.
REQ-002 The parameter DEPTH SHALL default to 256 and give the number of 16-bit words in the array, addressed by 8 bits.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, and is the reset: asynchronous, active-low.
REQ-005 Port en_ram_in SHALL be an input, 1 bit wide, and is the fetch request strobe from the control unit.
REQ-006 Port addr SHALL be an input, 8 bits wide, and is the fetch address (PC), sampled with en_ram_in.
REQ-007 Port ins SHALL be an output, 16 bits wide, and is the fetched instruction word.
REQ-008 Port en_ram_out SHALL be an output, 1 bit wide, and is a one-cycle strobe marking ins valid, which the IR latches on.
REQ-009 Port busy SHALL be an output, 1 bit wide, and is high while a fetch is in flight.
REQ-010 Port ld_we SHALL be an input, 1 bit wide, and is the loader write request, level-held until acknowledged.
REQ-011 Port ld_addr SHALL be an input, 8 bits wide, and is the loader write address.
REQ-012 Port ld_data SHALL be an input, 16 bits wide, and is the loader write data.
REQ-013 Port ld_ack SHALL be an output, 1 bit wide, and is a one-cycle pulse confirming the loader write.
REQ-014 Port drop_err SHALL be an output, 1 bit wide, and is a sticky flag set when a fetch request is dropped.

Function
REQ-015 The FSM SHALL have three states, IDLE, WAIT and RESP, with busy = (state != IDLE).
REQ-016 A fetch SHALL be accepted when en_ram_in=1 in IDLE at a rising edge; that edge latches addr into an internal address register.
REQ-017 On acceptance with LATENCY=1, the FSM SHALL go to RESP and load ins from mem[latched addr] at the same edge.
REQ-018 On acceptance with LATENCY>1, the FSM SHALL go to WAIT with a counter cnt=LATENCY-2.
REQ-019 In WAIT, if cnt=0 the FSM SHALL go to RESP and load ins from mem[latched addr]; otherwise it SHALL decrement cnt and stay in WAIT.
REQ-020 In RESP, en_ram_out SHALL be 1 for exactly one cycle; the FSM then SHALL return to IDLE.
REQ-021 en_ram_out SHALL be sampled high at the LATENCY-th rising edge after the accepting edge.
REQ-022 ins SHALL hold its value until the next RESP load; the minimum request spacing is LATENCY+1 edges.
REQ-023 en_ram_in=1 sampled in WAIT or RESP SHALL be ignored (no queueing) and SHALL set drop_err=1, which stays set until reset.
REQ-024 A loader write SHALL occur only in IDLE with en_ram_in=0: mem[ld_addr]<=ld_data at that edge, and ld_ack=1 for the following cycle.
REQ-025 If ld_we and en_ram_in are both high in IDLE, the fetch SHALL win and the write SHALL stall, with ld_ack held low.
REQ-026 A loader write SHALL also stall while busy=1 and complete at the first eligible IDLE edge; the loader holds ld_we, ld_addr and ld_data until ld_ack.
REQ-027 During ld_ack=1 the loader SHALL deassert ld_we; a still-high ld_we on that edge is treated as a new write.
REQ-028 A write and a fetch read SHALL never occur on the same edge, so no read-during-write ambiguity exists.

Reset
REQ-029 With rst=0 the block SHALL asynchronously force: state=IDLE, cnt=0, ins=16'h0000, en_ram_out=0, busy=0, ld_ack=0, drop_err=0.
REQ-030 Reset SHALL leave memory contents unchanged.
REQ-031 Reset asserted mid-fetch SHALL abort the fetch with no en_ram_out pulse; the first edge after deassertion is treated as IDLE.

Verification
REQ-032 The bench SHALL cover load: ld_we with ld_addr=8'h05 and ld_data=16'hA3C1 in IDLE -> ld_ack pulses one cycle later, and mem[5]=A3C1.
REQ-033 The bench SHALL cover LATENCY=2: en_ram_in=1 with addr=5 at edge k -> busy high, en_ram_out=1 sampled at edge k+2, ins=16'hA3C1, then IDLE.
REQ-034 The bench SHALL cover LATENCY=1 back-to-back: requests to addr 5 at edges k and k+2 -> two strobes sampled at k+1 and k+3, with no drop_err.
REQ-035 The bench SHALL cover a dropped request: en_ram_in=1 at edge k+1 while in WAIT -> request ignored, drop_err=1 and staying set, and the original response unaffected.
REQ-036 The bench SHALL cover a simultaneous fetch and load in IDLE: fetch accepted and ld_ack low until the FSM returns to IDLE, after which the write lands and the fetched ins reflects the old mem contents.
REQ-037 The bench SHALL cover reset mid-operation: rst=0 during WAIT -> outputs zero immediately, no en_ram_out pulse, and mem[5] still 16'hA3C1 on refetch.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: a 16-bit word array serving PC fetches from the
// control unit with a fixed LATENCY, plus a handshaked loader write port that
// only lands while no fetch is in flight.
module instr_mem_responder #(
  parameter int LATENCY = 2,  // legal range 1..7
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        en_ram_in,
  input  logic [7:0]  addr,
  output logic [15:0] ins,
  output logic        en_ram_out,
  output logic        busy,
  input  logic        ld_we,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ack,
  output logic        drop_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // WAIT is entered with this count so RESP is reached LATENCY-1 edges later.
  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  logic [15:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] ins_q, ins_d;
  logic        en_ram_out_q, en_ram_out_d;
  logic        ld_ack_q, ld_ack_d;
  logic        drop_err_q, drop_err_d;
  logic        mem_we;

  // Next-state, response and loader arbitration; a fetch always beats a write.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    ins_d        = ins_q;
    en_ram_out_d = 1'b0;
    ld_ack_d     = 1'b0;
    drop_err_d   = drop_err_q;
    mem_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_ram_in) begin
          addr_d = addr;
          if (LATENCY == 1) begin
            state_d      = S_RESP;
            ins_d        = mem[addr];
            en_ram_out_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else if (ld_we) begin
          mem_we   = 1'b1;
          ld_ack_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (en_ram_in) drop_err_d = 1'b1;
        if (cnt_q == 3'd0) begin
          state_d      = S_RESP;
          ins_d        = mem[addr_q];
          en_ram_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (en_ram_in) drop_err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any fetch in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      addr_q       <= 8'h00;
      ins_q        <= 16'h0000;
      en_ram_out_q <= 1'b0;
      ld_ack_q     <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      ins_q        <= ins_d;
      en_ram_out_q <= en_ram_out_d;
      ld_ack_q     <= ld_ack_d;
      drop_err_q   <= drop_err_d;
    end
  end

  // Word array write port, driven only by the loader.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps onto RAM and keeps the loaded
    // program across a reset of the control logic.
    if (mem_we) mem[ld_addr] <= ld_data;
  end

  assign ins        = ins_q;
  assign en_ram_out = en_ram_out_q;
  assign busy       = (state_q != S_IDLE);
  assign ld_ack     = ld_ack_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: a LATENCY=2 instance (a_*) and a LATENCY=1 instance (b_*)
// sharing clock and reset. Inputs change 1ns after a rising edge and outputs
// are checked at that same point, so "edge k" is the edge that samples a request.
module tb_instr_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_en_ram_in = 1'b0, a_ld_we = 1'b0;
  logic [7:0]  a_addr = 8'h00, a_ld_addr = 8'h00;
  logic [15:0] a_ld_data = 16'h0000;
  logic [15:0] a_ins;
  logic        a_en_ram_out, a_busy, a_ld_ack, a_drop_err;

  logic        b_en_ram_in = 1'b0, b_ld_we = 1'b0;
  logic [7:0]  b_addr = 8'h00, b_ld_addr = 8'h00;
  logic [15:0] b_ld_data = 16'h0000;
  logic [15:0] b_ins;
  logic        b_en_ram_out, b_busy, b_ld_ack, b_drop_err;

  int n_cmp = 0;
  int n_err = 0;

  instr_mem_responder #(.LATENCY(2), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .en_ram_in(a_en_ram_in), .addr(a_addr), .ins(a_ins),
    .en_ram_out(a_en_ram_out), .busy(a_busy), .ld_we(a_ld_we), .ld_addr(a_ld_addr),
    .ld_data(a_ld_data), .ld_ack(a_ld_ack), .drop_err(a_drop_err)
  );

  instr_mem_responder #(.LATENCY(1), .DEPTH(256)) dut_b (
    .clk(clk), .rst(rst), .en_ram_in(b_en_ram_in), .addr(b_addr), .ins(b_ins),
    .en_ram_out(b_en_ram_out), .busy(b_busy), .ld_we(b_ld_we), .ld_addr(b_ld_addr),
    .ld_data(b_ld_data), .ld_ack(b_ld_ack), .drop_err(b_drop_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loader write on instance A, checking the one-cycle ld_ack pulse.
  task automatic load_a(input logic [7:0] la, input logic [15:0] ld);
    a_ld_we = 1'b1; a_ld_addr = la; a_ld_data = ld;
    step();
    check("a_ld_ack_pulse", 32'(a_ld_ack), 32'h1);
    a_ld_we = 1'b0;
    step();
    check("a_ld_ack_clear", 32'(a_ld_ack), 32'h0);
  endtask

  initial begin
    // Reset state
    #1;
    check("a_rst_ins",  32'(a_ins), 32'h0);
    check("a_rst_strb", 32'(a_en_ram_out), 32'h0);
    check("a_rst_busy", 32'(a_busy), 32'h0);
    check("a_rst_ack",  32'(a_ld_ack), 32'h0);
    check("a_rst_drop", 32'(a_drop_err), 32'h0);
    check("b_rst_busy", 32'(b_busy), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step();

    // Load mem[5] = A3C1 on both instances
    load_a(8'h05, 16'hA3C1);
    b_ld_we = 1'b1; b_ld_addr = 8'h05; b_ld_data = 16'hA3C1;
    step();
    check("b_ld_ack_pulse", 32'(b_ld_ack), 32'h1);
    b_ld_we = 1'b0;
    step();
    check("b_ld_ack_clear", 32'(b_ld_ack), 32'h0);

    // LATENCY=2 fetch of addr 5
    a_en_ram_in = 1'b1; a_addr = 8'h05;
    step();                                   // edge k
    a_en_ram_in = 1'b0;
    check("l2_busy_k",   32'(a_busy), 32'h1);
    check("l2_strb_k",   32'(a_en_ram_out), 32'h0);
    step();                                   // edge k+1
    check("l2_strb_k1",  32'(a_en_ram_out), 32'h1);
    check("l2_ins",      32'(a_ins), 32'hA3C1);
    check("l2_busy_k1",  32'(a_busy), 32'h1);
    step();                                   // edge k+2
    check("l2_strb_end", 32'(a_en_ram_out), 32'h0);
    check("l2_idle",     32'(a_busy), 32'h0);
    check("l2_ins_hold", 32'(a_ins), 32'hA3C1);
    check("l2_no_drop",  32'(a_drop_err), 32'h0);

    // LATENCY=1 back-to-back at edges k and k+2
    b_en_ram_in = 1'b1; b_addr = 8'h05;
    step();                                   // edge k
    b_en_ram_in = 1'b0;
    check("l1_strb_1",   32'(b_en_ram_out), 32'h1);
    check("l1_ins_1",    32'(b_ins), 32'hA3C1);
    check("l1_busy_1",   32'(b_busy), 32'h1);
    step();                                   // edge k+1
    check("l1_gap_strb", 32'(b_en_ram_out), 32'h0);
    check("l1_gap_busy", 32'(b_busy), 32'h0);
    b_en_ram_in = 1'b1;
    step();                                   // edge k+2
    b_en_ram_in = 1'b0;
    check("l1_strb_2",   32'(b_en_ram_out), 32'h1);
    check("l1_ins_2",    32'(b_ins), 32'hA3C1);
    step();                                   // edge k+3
    check("l1_strb_end", 32'(b_en_ram_out), 32'h0);
    check("l1_no_drop",  32'(b_drop_err), 32'h0);

    // Dropped request while in WAIT
    a_en_ram_in = 1'b1; a_addr = 8'h05;
    step();                                   // edge k: accepted
    a_addr = 8'h07;                           // stays high into WAIT
    step();                                   // edge k+1: dropped
    a_en_ram_in = 1'b0;
    check("drop_strb",   32'(a_en_ram_out), 32'h1);
    check("drop_ins",    32'(a_ins), 32'hA3C1);
    check("drop_flag",   32'(a_drop_err), 32'h1);
    step();
    check("drop_idle",   32'(a_busy), 32'h0);
    check("drop_nostrb", 32'(a_en_ram_out), 32'h0);
    step();
    check("drop_nostrb2", 32'(a_en_ram_out), 32'h0);
    check("drop_sticky", 32'(a_drop_err), 32'h1);

    // Simultaneous fetch and load in IDLE: fetch wins, write lands afterwards
    a_en_ram_in = 1'b1; a_addr = 8'h05;
    a_ld_we = 1'b1; a_ld_addr = 8'h05; a_ld_data = 16'hBEEF;
    step();                                   // edge k
    a_en_ram_in = 1'b0;
    check("sim_busy",    32'(a_busy), 32'h1);
    check("sim_ack_k",   32'(a_ld_ack), 32'h0);
    step();                                   // edge k+1
    check("sim_strb",    32'(a_en_ram_out), 32'h1);
    check("sim_old_ins", 32'(a_ins), 32'hA3C1);
    check("sim_ack_k1",  32'(a_ld_ack), 32'h0);
    step();                                   // edge k+2: back to IDLE
    check("sim_ack_k2",  32'(a_ld_ack), 32'h0);
    step();                                   // edge k+3: write lands
    check("sim_ack_k3",  32'(a_ld_ack), 32'h1);
    a_ld_we = 1'b0;
    step();
    check("sim_ack_off", 32'(a_ld_ack), 32'h0);
    a_en_ram_in = 1'b1; a_addr = 8'h05;
    step();
    a_en_ram_in = 1'b0;
    step();
    check("sim_new_ins", 32'(a_ins), 32'hBEEF);
    step();
    load_a(8'h05, 16'hA3C1);

    // Reset during WAIT
    a_en_ram_in = 1'b1; a_addr = 8'h05;
    step();
    a_en_ram_in = 1'b0;
    check("rw_busy_pre", 32'(a_busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rw_busy",     32'(a_busy), 32'h0);
    check("rw_ins",      32'(a_ins), 32'h0);
    check("rw_strb",     32'(a_en_ram_out), 32'h0);
    check("rw_drop",     32'(a_drop_err), 32'h0);
    step();
    check("rw_strb_hold", 32'(a_en_ram_out), 32'h0);
    @(negedge clk) rst = 1'b1;
    step();
    check("rw_strb_post", 32'(a_en_ram_out), 32'h0);
    check("rw_busy_post", 32'(a_busy), 32'h0);
    a_en_ram_in = 1'b1; a_addr = 8'h05;
    step();
    a_en_ram_in = 1'b0;
    step();
    check("rw_refetch_strb", 32'(a_en_ram_out), 32'h1);
    check("rw_refetch_ins",  32'(a_ins), 32'hA3C1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
